// File: rtl/my_nios1_cpu_cpu_debug_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : my_nios1_cpu_cpu_debug_host_pkg                                   |
// | Shared types and constants for the Nios II debug-host virtual-JTAG driver:  |
// | the sequencer state encoding and the virtual IR instruction codes.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package my_nios1_cpu_cpu_debug_host_pkg;

    // Virtual-JTAG walk performed for every command.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5,
        RSP  = 3'd6
    } host_state_t;

    // Virtual IR codes understood by the debug slave.
    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // TCK only runs while a scan is in progress.
    function automatic logic is_scan_state(input host_state_t s);
        return (s != IDLE) && (s != RSP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_nios1_cpu_cpu_debug_host_tckgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : my_nios1_cpu_cpu_debug_host_tckgen                                |
// | TCK divider. While enabled, tck is low for TCK_DIV clks then high for       |
// | TCK_DIV clks; o_tck_rise / o_tck_fall are one-clk pulses in the cycle whose |
// | closing clk edge toggles tck. Disabled: tck held low, divider cleared, so   |
// | every scan starts with a full low half-period.                              |
// | Ports   : clk, reset_n (async, active low), i_enable,                       |
// |           o_tck, o_tck_rise, o_tck_fall                                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module my_nios1_cpu_cpu_debug_host_tckgen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    output logic o_tck,
    output logic o_tck_rise,
    output logic o_tck_fall
);

    localparam logic [7:0] c_half_last = 8'(TCK_DIV - 1);

    logic [7:0] r_div;
    logic       r_tck;
    logic       w_half_end;

    assign w_half_end = i_enable && (r_div == c_half_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 8'd0;
            r_tck <= 1'b0;
        end else if (!i_enable) begin
            r_div <= 8'd0;
            r_tck <= 1'b0;
        end else if (w_half_end) begin
            r_div <= 8'd0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    assign o_tck      = r_tck;
    assign o_tck_rise = w_half_end && !r_tck;
    assign o_tck_fall = w_half_end &&  r_tck;

endmodule
`default_nettype wire

// File: rtl/my_nios1_cpu_cpu_debug_host_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : my_nios1_cpu_cpu_debug_host_driver                                |
// | System-clock virtual-JTAG initiator for the Nios II debug slave. Accepts    |
// | one {IR, DR} command, walks UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI,     |
// | one TCK period each, and returns the captured DR (first tdo bit in bit 0).  |
// | Ports   : clk, reset_n; cmd_valid/cmd_ready/cmd_ir/cmd_data;                |
// |           rsp_valid/rsp_ready/rsp_data; vji_tck/vji_tdi/vji_tdo/vji_ir_in;  |
// |           vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti strobes.                  |
// | Option  : DEBUG_HOST_IR_CACHE_EN - remember the last IR and skip UIR when   |
// |           the next command uses the same IR (first command after reset      |
// |           always performs UIR).                                             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module my_nios1_cpu_cpu_debug_host_driver
    import my_nios1_cpu_cpu_debug_host_pkg::*;
#(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int                   c_cnt_w    = $clog2(DR_WIDTH + 1);
    localparam logic [c_cnt_w-1:0]   c_last_bit = c_cnt_w'(DR_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]   c_bit_sat  = c_cnt_w'(DR_WIDTH);

    host_state_t         r_state;
    host_state_t         w_next_state;
    logic                w_accept;
    logic                w_skip_uir;
    logic                w_tck_rise;
    logic                w_tck_fall;
    logic [DR_WIDTH-1:0] r_sr;
    logic                r_tdo_q;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [IR_WIDTH-1:0] r_ir;
    logic [DR_WIDTH-1:0] r_rsp_data;

    assign w_accept = cmd_valid && (r_state == IDLE);

    my_nios1_cpu_cpu_debug_host_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_enable   (is_scan_state(r_state)),
        .o_tck      (vji_tck),
        .o_tck_rise (w_tck_rise),
        .o_tck_fall (w_tck_fall)
    );

`ifdef DEBUG_HOST_IR_CACHE_EN
    // r_ir doubles as the cached IR; the flag says whether it has ever been loaded.
    logic r_ir_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_valid <= 1'b0;
        end else if (w_accept) begin
            r_ir_valid <= 1'b1;
        end
    end

    assign w_skip_uir = r_ir_valid && (cmd_ir == r_ir);
`else
    assign w_skip_uir = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Scan states advance on tck falling edges only, so every output change
    // lands on a TCK period boundary.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)  w_next_state = w_skip_uir ? CDR : UIR;
            UIR:     if (w_tck_fall) w_next_state = CDR;
            CDR:     if (w_tck_fall) w_next_state = SDR;
            SDR:     if (w_tck_fall && (r_bit_cnt == c_last_bit)) w_next_state = UDR;
            UDR:     if (w_tck_fall) w_next_state = RTI;
            RTI:     if (w_tck_fall) w_next_state = RSP;
            RSP:     if (rsp_ready)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr       <= '0;
            r_tdo_q    <= 1'b0;
            r_bit_cnt  <= '0;
            r_ir       <= IR_WIDTH'(IR_OCIMEM);
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_ir <= cmd_ir;
                r_sr <= cmd_data;
            end
            if ((r_state == SDR) && w_tck_rise) begin
                r_tdo_q <= vji_tdo;
            end
            // tdo captured mid-period enters at the MSB as tdi leaves the LSB.
            if ((r_state == SDR) && w_tck_fall) begin
                r_sr <= {r_tdo_q, r_sr[DR_WIDTH-1:1]};
            end
            if (r_state == CDR) begin
                r_bit_cnt <= '0;
            end else if ((r_state == SDR) && w_tck_fall && (r_bit_cnt != c_bit_sat)) begin
                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
            end
            if ((r_state == RTI) && w_tck_fall) begin
                r_rsp_data <= r_sr;
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RSP);
    assign rsp_data  = r_rsp_data;
    assign vji_ir_in = r_ir;
    assign vji_tdi   = (r_state == SDR) ? r_sr[0] : 1'b0;
    assign vji_uir   = (r_state == UIR);
    assign vji_cdr   = (r_state == CDR);
    assign vji_sdr   = (r_state == SDR);
    assign vji_udr   = (r_state == UDR);
    assign vji_rti   = (r_state == RTI);

endmodule
`default_nettype wire

// File: tb/tb_my_nios1_cpu_cpu_debug_host_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_my_nios1_cpu_cpu_debug_host_driver                             |
// | Self-checking bench: instance A (TCK_DIV=2) and instance B (TCK_DIV=1),     |
// | each attached to a simple debug-slave model (loads a value on cdr, shifts   |
// | tdi in on tck rise during sdr, tdo = reg[0]).                               |
// | Option  : DEBUG_HOST_IR_CACHE_EN changes the expected UIR skipping.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_my_nios1_cpu_cpu_debug_host_driver;

    localparam int W = 38;
    localparam int D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // instance A
    logic         a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready;
    logic [1:0]   a_cmd_ir, a_ir_in;
    logic [W-1:0] a_cmd_data, a_rsp_data;
    logic         a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;
    // instance B
    logic         b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0]   b_cmd_ir, b_ir_in;
    logic [W-1:0] b_cmd_data, b_rsp_data;
    logic         b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model of the IR cache
    bit         m_valid = 1'b0;
    logic [1:0] m_last  = 2'b00;

    my_nios1_cpu_cpu_debug_host_driver #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(D)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ir(a_cmd_ir), .cmd_data(a_cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo), .vji_ir_in(a_ir_in),
        .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti)
    );

    my_nios1_cpu_cpu_debug_host_driver #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo), .vji_ir_in(b_ir_in),
        .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
    );

    // ---------------- slave models ----------------
    logic [W-1:0] sa_reg = '0, sa_load = '0, sa_udr_snap = '0;
    assign a_tdo = sa_reg[0];
    always @(posedge a_tck) begin
        if (a_cdr)      sa_reg <= sa_load;
        else if (a_sdr) sa_reg <= {a_tdi, sa_reg[W-1:1]};
        if (a_udr)      sa_udr_snap <= sa_reg;
    end

    logic [W-1:0] sb_reg = '0, sb_udr_snap = '0;
    int           sb_ones = 0;
    assign b_tdo = sb_reg[0];
    always @(posedge b_tck) begin
        if (b_cdr)      sb_reg <= '0;
        else if (b_sdr) sb_reg <= {b_tdi, sb_reg[W-1:1]};
        if (b_udr)      sb_udr_snap <= sb_reg;
        if (b_sdr && b_tdi) sb_ones = sb_ones + 1;
    end

    // ---------------- strobe monitor (instance A) ----------------
    bit         mon_en = 1'b0;
    logic [4:0] mon_vec[$];
    int         mon_len[$];
    int         mon_multi = 0;
    int         mon_tck_rises = 0;
    logic [4:0] mon_v;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_v = {a_uir, a_cdr, a_sdr, a_udr, a_rti};
            if ($countones(mon_v) > 1) mon_multi = mon_multi + 1;
            if (mon_v != 5'b0) begin
                if (mon_vec.size() == 0 || mon_vec[mon_vec.size()-1] != mon_v) begin
                    mon_vec.push_back(mon_v);
                    mon_len.push_back(1);
                end else begin
                    mon_len[mon_len.size()-1] = mon_len[mon_len.size()-1] + 1;
                end
            end
        end
    end

    always @(posedge a_tck) if (mon_en) mon_tck_rises = mon_tck_rises + 1;

    // ---------------- model helpers ----------------
    function automatic bit model_skip(input logic [1:0] ir);
`ifdef DEBUG_HOST_IR_CACHE_EN
        return m_valid && (m_last == ir);
`else
        return 1'b0;
`endif
    endfunction

    // Each walk step is one TCK period; SDR lasts one period per DR bit.
    function automatic int exp_lat(input bit skip, input int d);
        return 2 * d * (W + 4 - (skip ? 1 : 0));
    endfunction

    function automatic bit strobe_seq_ok(input bit skip);
        logic [4:0] ev[$];
        int         el[$];
        if (!skip) begin ev.push_back(5'b10000); el.push_back(2*D); end
        ev.push_back(5'b01000); el.push_back(2*D);
        ev.push_back(5'b00100); el.push_back(2*D*W);
        ev.push_back(5'b00010); el.push_back(2*D);
        ev.push_back(5'b00001); el.push_back(2*D);
        if (mon_vec.size() != ev.size()) return 1'b0;
        foreach (ev[i]) if (mon_vec[i] !== ev[i] || mon_len[i] != el[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Drives one command on A and waits (bounded) for the response; no checking here.
    task automatic do_cmd(input logic [1:0] ir, input logic [W-1:0] data, input logic [W-1:0] load,
                          output int lat, output logic [W-1:0] rsp, output logic [1:0] ir_seen,
                          output bit ok);
        int t;
        ok = 1'b0; lat = 0; rsp = '0; ir_seen = 2'b00;
        sa_load = load;
        t = 0;
        while (!a_cmd_ready && t < 1000) begin @(negedge clk); t++; end
        if (!a_cmd_ready) return;
        mon_vec.delete(); mon_len.delete(); mon_multi = 0; mon_tck_rises = 0;
        a_cmd_ir = ir; a_cmd_data = data; a_cmd_valid = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        ir_seen = a_ir_in;
        while (!a_rsp_valid && lat < 5000) begin @(negedge clk); lat++; end
        mon_en = 1'b0;
        ok = a_rsp_valid;
        rsp = a_rsp_data;
        m_valid = 1'b1; m_last = ir;
    endtask

    task automatic release_a();
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
    endtask

    // Full command on A with every per-command comparison.
    task automatic run_and_check(input string name, input logic [1:0] ir,
                                 input logic [W-1:0] data, input logic [W-1:0] load);
        int lat; logic [W-1:0] rsp; logic [1:0] irs; bit ok; bit skip;
        skip = model_skip(ir);
        do_cmd(ir, data, load, lat, rsp, irs, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL %s_timeout: rsp_valid=%b after %0d clks, required 1", name, a_rsp_valid, lat);
            return;
        end
        n_tests++;
        if (lat != exp_lat(skip, D)) begin n_fail++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat(skip, D)); end
        n_tests++;
        if (rsp !== load) begin n_fail++; $display("FAIL %s_rsp_data: got %h required %h", name, rsp, load); end
        n_tests++;
        if (sa_udr_snap !== data) begin n_fail++; $display("FAIL %s_slave_dr: got %h required %h", name, sa_udr_snap, data); end
        n_tests++;
        if (irs !== ir || a_ir_in !== ir) begin n_fail++; $display("FAIL %s_ir_in: got %b/%b required %b", name, irs, a_ir_in, ir); end
        n_tests++;
        if (!strobe_seq_ok(skip) || mon_multi != 0) begin
            n_fail++; $display("FAIL %s_strobes: runs=%0d multi=%0d required runs=%0d multi=0", name, mon_vec.size(), mon_multi, skip ? 4 : 5);
        end
        n_tests++;
        if (mon_tck_rises != W + 4 - (skip ? 1 : 0)) begin
            n_fail++; $display("FAIL %s_tck_count: got %0d required %0d", name, mon_tck_rises, W + 4 - (skip ? 1 : 0));
        end
        release_a();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++;
        if ({a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_cmd_ready, a_rsp_valid} !== 11'b00000000010) begin
            n_fail++; $display("FAIL reset_a_ctrl: got %b required 00000000010",
                {a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_cmd_ready, a_rsp_valid});
        end
        n_tests++;
        if (a_rsp_data !== '0) begin n_fail++; $display("FAIL reset_a_rsp_data: got %h required 0", a_rsp_data); end
        n_tests++;
        if ({b_tck, b_tdi, b_ir_in, b_uir, b_cdr, b_sdr, b_udr, b_rti, b_cmd_ready, b_rsp_valid, b_rsp_data} !== {11'b00000000010, {W{1'b0}}}) begin
            n_fail++; $display("FAIL reset_b: got %b_%h required 00000000010_0",
                {b_tck, b_tdi, b_ir_in, b_uir, b_cdr, b_sdr, b_udr, b_rti, b_cmd_ready, b_rsp_valid}, b_rsp_data);
        end
    endtask

    task automatic test_basic();
        run_and_check("basic", 2'b10, 38'h15_A5A5A5A5, 38'h2A_5A5A5A5A);
    endtask

    task automatic test_rsp_hold();
        int lat; logic [W-1:0] rsp, data, load; logic [1:0] irs; bit ok; bit bad;
        logic [63:0] rnd;
        rnd = {$urandom, $urandom}; data = rnd[W-1:0];
        rnd = {$urandom, $urandom}; load = rnd[W-1:0];
        do_cmd(2'b00, data, load, lat, rsp, irs, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL hold_timeout: rsp_valid=%b required 1", a_rsp_valid); return; end
        bad = 1'b0;
        a_cmd_ir = 2'b11; a_cmd_data = ~data;
        for (int i = 0; i < 20; i++) begin
            a_cmd_valid = 1'b1;
            @(negedge clk);
            if (a_rsp_valid !== 1'b1 || a_rsp_data !== load || a_cmd_ready !== 1'b0 || a_tck !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL hold_stable: valid=%b data=%h ready=%b required 1 %h 0", a_rsp_valid, a_rsp_data, a_cmd_ready, load); end
        a_cmd_valid = 1'b0;
        release_a();
        n_tests++;
        if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0 || {a_uir, a_cdr} !== 2'b00 || a_ir_in !== 2'b00) begin
            n_fail++; $display("FAIL hold_release: ready=%b valid=%b uir/cdr=%b ir=%b required 1 0 00 00", a_cmd_ready, a_rsp_valid, {a_uir, a_cdr}, a_ir_in);
        end
        bad = 1'b0;
        a_rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0) bad = 1'b1;
        end
        a_rsp_ready = 1'b0;
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL idle_rsp_ready: ready=%b valid=%b required 1 0", a_cmd_ready, a_rsp_valid); end
    endtask

    task automatic test_random();
        logic [63:0] rnd; logic [W-1:0] data, load; logic [1:0] ir;
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom}; data = rnd[W-1:0];
            rnd = {$urandom, $urandom}; load = rnd[W-1:0];
            ir = (i % 2 == 1) ? m_last : 2'($urandom_range(0, 3));
            run_and_check("random", ir, data, load);
        end
    endtask

    task automatic test_reset_midscan();
        int t;
        logic [63:0] rnd; logic [W-1:0] data;
        rnd = {$urandom, $urandom}; data = rnd[W-1:0];
        t = 0;
        while (!a_cmd_ready && t < 1000) begin @(negedge clk); t++; end
        sa_load = '1;
        a_cmd_ir = 2'b11; a_cmd_data = data; a_cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_cmd_valid = 1'b0;
        repeat (99) @(negedge clk);
        n_tests++;
        if (a_sdr !== 1'b1) begin n_fail++; $display("FAIL midscan_in_sdr: sdr=%b required 1", a_sdr); end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_cmd_ready, a_rsp_valid} !== 11'b00000000010 || a_rsp_data !== '0) begin
            n_fail++; $display("FAIL midscan_async: got %b_%h required 00000000010_0",
                {a_tck, a_tdi, a_ir_in, a_uir, a_cdr, a_sdr, a_udr, a_rti, a_cmd_ready, a_rsp_valid}, a_rsp_data);
        end
        @(negedge clk);
        n_tests++;
        if ({a_tck, a_cmd_ready, a_rsp_valid, a_sdr} !== 4'b0100) begin
            n_fail++; $display("FAIL midscan_next: tck/ready/valid/sdr=%b required 0100", {a_tck, a_cmd_ready, a_rsp_valid, a_sdr});
        end
        reset_n = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        rnd = {$urandom, $urandom};
        run_and_check("after_reset", 2'b11, data, rnd[W-1:0]);
    endtask

    task automatic test_ir_cache();
        run_and_check("cache_first", 2'b01, 38'h0F_0F0F0F0F, 38'h30_F0F0F0F0);
        run_and_check("cache_second", 2'b01, 38'h33_33333333, 38'h0C_CCCCCCCC);
    endtask

    task automatic test_tckdiv1();
        int lat;
        n_tests++;
        if (b_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL div1_ready: got %b required 1", b_cmd_ready); end
        sb_ones = 0;
        b_cmd_ir = 2'b00; b_cmd_data = '1; b_cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_cmd_valid = 1'b0;
        lat = 0;
        while (!b_rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        n_tests++;
        if (lat != exp_lat(1'b0, 1)) begin n_fail++; $display("FAIL div1_latency: got %0d required %0d", lat, exp_lat(1'b0, 1)); end
        n_tests++;
        if (b_rsp_data !== '0) begin n_fail++; $display("FAIL div1_rsp_data: got %h required 0", b_rsp_data); end
        n_tests++;
        if (sb_ones != W) begin n_fail++; $display("FAIL div1_tdi_ones: got %0d required %0d", sb_ones, W); end
        n_tests++;
        if (sb_udr_snap !== {W{1'b1}}) begin n_fail++; $display("FAIL div1_slave_dr: got %h required all ones", sb_udr_snap); end
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_cmd_valid = 1'b0; a_rsp_ready = 1'b0; a_cmd_ir = 2'b00; a_cmd_data = '0;
        b_cmd_valid = 1'b0; b_rsp_ready = 1'b0; b_cmd_ir = 2'b00; b_cmd_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_rsp_hold();
        test_random();
        test_reset_midscan();
        test_ir_cache();
        test_tckdiv1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
